// File: rtl/cbc_ctl_out_pkg.sv
// -----------------------------------------------------------------------------
// cbc_ctl_out_pkg
// Shared AES controller definitions used by the output controller and its
// input-side counterpart: output FIFO framing tags, work-mode encoding,
// output FSM state encoding and small helpers on the packet length field.
// -----------------------------------------------------------------------------
package cbc_ctl_out_pkg;

   // AES block width and number of output words per block.
   localparam int BLK_W         = 128;
   localparam int WORDS_PER_BLK = 4;

   // Framing tags carried in the top bits of every output FIFO word.
   localparam logic [1:0] TAG_HEAD = 2'b01;
   localparam logic [1:0] TAG_BODY = 2'b00;
   localparam logic [1:0] TAG_LAST = 2'b10;

   // Work mode as presented on i_mode.
   typedef enum logic {
      MODE_ENC = 1'b0,
      MODE_DEC = 1'b1
   } mode_e;

   // Output serializer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_WORD = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // A packet must be a non-zero whole number of 128-bit blocks.
   function automatic logic len_illegal(input logic [7:0] len);
      return (len[1:0] != 2'b00) || (len == 8'd0);
   endfunction

   // Index of the final block of a packet of 'len' 32-bit words.
   function automatic logic [5:0] last_blk_idx(input logic [7:0] len);
      return len[7:2] - 6'd1;
   endfunction

endpackage

// File: rtl/cbc_ctl_out_if.sv
// -----------------------------------------------------------------------------
// cbc_ctl_out_if
// Bundles the AES-result, packet-context and output-FIFO signals of the CBC
// output controller.
//   slave  : view of the output controller (AES/context/full in, FIFO out)
//   master : view of the surrounding logic driving it
// Signals:
//   i_data_out_aes  AES core result block
//   i_done_aes      one-cycle pulse, i_data_out_aes valid
//   i_data_in_aes   block that was fed to the AES core
//   i_iv            packet IV, stable from packet start
//   i_mode          0 = encrypt, 1 = decrypt
//   data_len        packet payload length in 32-bit words
//   i_full_fifo     output FIFO full
//   o_wr_out        output FIFO write strobe
//   o_data_out      output FIFO word {tag, payload}
//   data_chain      CBC chaining value back to the input controller
//   done_data       one-cycle pulse, block fully emitted
//   o_error         sticky error flag
// -----------------------------------------------------------------------------
interface cbc_ctl_out_if
   import cbc_ctl_out_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int TAG_W  = 2
);

   logic [BLK_W-1:0]        i_data_out_aes;
   logic                    i_done_aes;
   logic [BLK_W-1:0]        i_data_in_aes;
   logic [BLK_W-1:0]        i_iv;
   logic                    i_mode;
   logic [7:0]              data_len;
   logic                    i_full_fifo;
   logic                    o_wr_out;
   logic [TAG_W+WORD_W-1:0] o_data_out;
   logic [BLK_W-1:0]        data_chain;
   logic                    done_data;
   logic                    o_error;

   modport slave (
      input  i_data_out_aes, i_done_aes, i_data_in_aes, i_iv, i_mode,
             data_len, i_full_fifo,
      output o_wr_out, o_data_out, data_chain, done_data, o_error
   );

   modport master (
      output i_data_out_aes, i_done_aes, i_data_in_aes, i_iv, i_mode,
             data_len, i_full_fifo,
      input  o_wr_out, o_data_out, data_chain, done_data, o_error
   );

endinterface

// File: rtl/cbc_chain.sv
// -----------------------------------------------------------------------------
// cbc_chain
// CBC chaining register plus the output XOR/select.
//   clk, rst  clock, synchronous active-high reset
//   load      capture strobe (a legal block capture)
//   first     current block is the first of its packet (use IV as chain)
//   mode      encrypt / decrypt
//   aes_out   AES core result
//   aes_in    block that was fed to the AES core
//   iv        packet IV
//   chain     chaining register
//   blk_val   plaintext/ciphertext block to be emitted for this capture
// -----------------------------------------------------------------------------
module cbc_chain
   import cbc_ctl_out_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             first,
   input  mode_e            mode,
   input  logic [BLK_W-1:0] aes_out,
   input  logic [BLK_W-1:0] aes_in,
   input  logic [BLK_W-1:0] iv,
   output logic [BLK_W-1:0] chain,
   output logic [BLK_W-1:0] blk_val
);

   logic [BLK_W-1:0] prev;

   // The first block of a packet chains against the IV instead of the
   // register, which still holds the previous packet's last value.
   always_comb begin
      prev    = first ? iv : chain;
      blk_val = (mode == MODE_DEC) ? (aes_out ^ prev) : aes_out;
   end

   // Encrypt chains on the ciphertext the core produced; decrypt chains on
   // the ciphertext the core consumed.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         chain <= '0;
      end else if (load) begin
         chain <= (mode == MODE_DEC) ? aes_in : aes_out;
      end
   end

endmodule

// File: rtl/cbc_ctl_out.sv
// -----------------------------------------------------------------------------
// cbc_ctl_out
// CBC output controller. Captures each AES result block, applies the CBC
// XOR in decrypt mode, and serializes it into tagged output FIFO words: a
// header word ahead of the first block of a packet, then four payload words
// per block (low word first), the very last word of the packet tagged LAST.
// Flow control comes from the FIFO full flag; protocol violations (overrun
// or an illegal packet length) park the block in ERR until reset.
//   clk  clock
//   rst  synchronous active-high reset
//   bus  cbc_ctl_out_if.slave (AES result, packet context, FIFO side)
// -----------------------------------------------------------------------------
module cbc_ctl_out
   import cbc_ctl_out_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int TAG_W  = 2
)(
   input logic          clk,
   input logic          rst,
   cbc_ctl_out_if.slave bus
);

   state_e                  state;
   logic [1:0]              wcnt;
   logic [5:0]              blk_cnt;
   logic [BLK_W-1:0]        out_blk;
   logic [TAG_W+WORD_W-1:0] data_q;
   logic                    done_q;
   logic                    err_q;

   logic                    first_blk;
   logic                    last_blk;
   logic                    cap_bad;
   logic                    cap_ok;
   logic                    busy;
   logic [WORD_W-1:0]       hdr_word;
   logic [BLK_W-1:0]        blk_val;
   logic [1:0]              wnext;

   // Payload word 'idx' of a block, word 0 being bits [WORD_W-1:0].
   function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                  input logic [1:0]       idx);
      unique case (idx)
         2'd0: word_sel = blk[0*WORD_W +: WORD_W];
         2'd1: word_sel = blk[1*WORD_W +: WORD_W];
         2'd2: word_sel = blk[2*WORD_W +: WORD_W];
         2'd3: word_sel = blk[3*WORD_W +: WORD_W];
      endcase
   endfunction

   assign first_blk = (blk_cnt == 6'd0);
   assign last_blk  = (blk_cnt == last_blk_idx(bus.data_len));
   assign busy      = (state == ST_HDR) || (state == ST_WORD);
   assign cap_bad   = first_blk && len_illegal(bus.data_len);
   assign cap_ok    = (state == ST_IDLE) && bus.i_done_aes && !cap_bad;
   assign wnext     = wcnt + 2'd1;

   // Header payload: mode at bit 10, length in the low byte.
   always_comb begin
      // NOTE: default the whole word first so the partial assignments below
      // can never leave bits unassigned and infer a latch.
      hdr_word     = '0;
      hdr_word[7:0] = bus.data_len;
      hdr_word[10]  = bus.i_mode;
   end

   cbc_chain u_chain (
      .clk     (clk),
      .rst     (rst),
      .load    (cap_ok),
      .first   (first_blk),
      .mode    (mode_e'(bus.i_mode)),
      .aes_out (bus.i_data_out_aes),
      .aes_in  (bus.i_data_in_aes),
      .iv      (bus.i_iv),
      .chain   (bus.data_chain),
      .blk_val (blk_val)
   );

   // o_data_out always holds the word currently offered to the FIFO, so each
   // write loads the next word and a stalled write leaves it untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         wcnt    <= 2'd0;
         blk_cnt <= 6'd0;
         out_blk <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.i_done_aes) begin
                  if (cap_bad) begin
                     state <= ST_ERR;
                     err_q <= 1'b1;
                  end else begin
                     out_blk <= blk_val;
                     wcnt    <= 2'd0;
                     if (first_blk) begin
                        state  <= ST_HDR;
                        data_q <= {TAG_W'(TAG_HEAD), hdr_word};
                     end else begin
                        state  <= ST_WORD;
                        data_q <= {TAG_W'(TAG_BODY), word_sel(blk_val, 2'd0)};
                     end
                  end
               end
            end

            ST_HDR, ST_WORD: begin
               if (bus.i_done_aes) begin
                  // Overrun: a new result arrived before this one drained.
                  state <= ST_ERR;
                  err_q <= 1'b1;
               end else if (!bus.i_full_fifo) begin
                  if (state == ST_HDR) begin
                     state  <= ST_WORD;
                     data_q <= {TAG_W'(TAG_BODY), word_sel(out_blk, 2'd0)};
                  end else if (wcnt == 2'd3) begin
                     state   <= ST_IDLE;
                     wcnt    <= 2'd0;
                     done_q  <= 1'b1;
                     blk_cnt <= last_blk ? 6'd0 : blk_cnt + 6'd1;
                  end else begin
                     wcnt   <= wnext;
                     data_q <= {(wnext == 2'd3 && last_blk) ? TAG_W'(TAG_LAST)
                                                            : TAG_W'(TAG_BODY),
                                word_sel(out_blk, wnext)};
                  end
               end
            end

            ST_ERR: begin
               // Left only through reset.
            end
         endcase
      end
   end

   assign bus.o_wr_out   = busy && !bus.i_full_fifo;
   assign bus.o_data_out = data_q;
   assign bus.done_data  = done_q;
   assign bus.o_error    = err_q;

endmodule

// File: tb/tb_cbc_ctl_out.sv
// -----------------------------------------------------------------------------
// tb_cbc_ctl_out
// Directed bench for cbc_ctl_out. Each step drives inputs on the falling
// edge, then checks write strobe, FIFO word, done_data and o_error against
// hand-computed values; the rising edge that follows consumes the inputs.
// -----------------------------------------------------------------------------
module tb_cbc_ctl_out;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [127:0] BLK_X = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
   localparam logic [127:0] BLK_Y = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] BLK_D = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
   localparam logic [127:0] ONES  = {128{1'b1}};

   always #5 clk = ~clk;

   cbc_ctl_out_if #(.WORD_W(32), .TAG_W(2)) bus ();

   cbc_ctl_out #(.WORD_W(32), .TAG_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus plus the outputs expected during that clock.
   task automatic step(input string tag, input logic r, input logic d,
                       input logic f, input logic e_wr, input logic [33:0] e_dat,
                       input logic e_done, input logic e_err);
      @(negedge clk);
      rst             = r;
      bus.i_done_aes  = d;
      bus.i_full_fifo = f;
      #1;
      check({tag, ".wr"},   128'(bus.o_wr_out),   128'(e_wr));
      check({tag, ".data"}, 128'(bus.o_data_out), 128'(e_dat));
      check({tag, ".done"}, 128'(bus.done_data),  128'(e_done));
      check({tag, ".err"},  128'(bus.o_error),    128'(e_err));
   endtask

   task automatic cfg(input logic mode, input logic [7:0] len,
                      input logic [127:0] iv, input logic [127:0] aes_out,
                      input logic [127:0] aes_in);
      bus.i_mode         = mode;
      bus.data_len       = len;
      bus.i_iv           = iv;
      bus.i_data_out_aes = aes_out;
      bus.i_data_in_aes  = aes_in;
   endtask

   initial begin
      bus.i_done_aes  = 1'b0;
      bus.i_full_fifo = 1'b0;
      cfg(1'b0, 8'd4, '0, BLK_X, '0);

      // Reset state.
      step("rst",   1, 0, 0, 0, 34'h0_00000000, 0, 0);
      check("rst.chain", bus.data_chain, '0);

      // Encrypt, one block.
      step("e.cap", 0, 1, 0, 0, 34'h0_00000000, 0, 0);
      step("e.hdr", 0, 0, 0, 1, 34'h1_00000004, 0, 0);
      step("e.w0",  0, 0, 0, 1, 34'h0_FFEEDDCC, 0, 0);
      step("e.w1",  0, 0, 0, 1, 34'h0_BBAA9988, 0, 0);
      step("e.w2",  0, 0, 0, 1, 34'h0_77665544, 0, 0);
      step("e.w3",  0, 0, 0, 1, 34'h2_33221100, 0, 0);
      step("e.dn",  0, 0, 0, 0, 34'h2_33221100, 1, 0);
      check("e.chain", bus.data_chain, BLK_X);

      // Decrypt, two blocks; block 1 is all-ones XOR all-ones IV.
      cfg(1'b1, 8'd8, ONES, ONES, BLK_D);
      step("d.cap1", 0, 1, 0, 0, 34'h2_33221100, 0, 0);
      step("d.hdr",  0, 0, 0, 1, 34'h1_00000408, 0, 0);
      step("d.b1w0", 0, 0, 0, 1, 34'h0_00000000, 0, 0);
      step("d.b1w1", 0, 0, 0, 1, 34'h0_00000000, 0, 0);
      step("d.b1w2", 0, 0, 0, 1, 34'h0_00000000, 0, 0);
      step("d.b1w3", 0, 0, 0, 1, 34'h0_00000000, 0, 0);
      bus.i_data_out_aes = '0;
      step("d.dn1",  0, 1, 0, 0, 34'h0_00000000, 1, 0);
      check("d.chain1", bus.data_chain, BLK_D);
      step("d.b2w0", 0, 0, 0, 1, 34'h0_89ABCDEF, 0, 0);
      step("d.b2w1", 0, 0, 0, 1, 34'h0_01234567, 0, 0);
      step("d.b2w2", 0, 0, 0, 1, 34'h0_89ABCDEF, 0, 0);
      step("d.b2w3", 0, 0, 0, 1, 34'h2_01234567, 0, 0);
      step("d.dn2",  0, 0, 0, 0, 34'h2_01234567, 1, 0);
      check("d.chain2", bus.data_chain, BLK_D);

      // FIFO full for three cycles while word 1 is offered.
      cfg(1'b0, 8'd4, '0, BLK_Y, '0);
      step("f.cap",  0, 1, 0, 0, 34'h2_01234567, 0, 0);
      step("f.hdr",  0, 0, 0, 1, 34'h1_00000004, 0, 0);
      step("f.w0",   0, 0, 0, 1, 34'h0_AAAAAAAA, 0, 0);
      step("f.st1",  0, 0, 1, 0, 34'h0_BBBBBBBB, 0, 0);
      step("f.st2",  0, 0, 1, 0, 34'h0_BBBBBBBB, 0, 0);
      step("f.st3",  0, 0, 1, 0, 34'h0_BBBBBBBB, 0, 0);
      step("f.w1",   0, 0, 0, 1, 34'h0_BBBBBBBB, 0, 0);
      step("f.w2",   0, 0, 0, 1, 34'h0_CCCCCCCC, 0, 0);
      step("f.w3",   0, 0, 0, 1, 34'h2_DDDDDDDD, 0, 0);
      step("f.dn",   0, 0, 0, 0, 34'h2_DDDDDDDD, 1, 0);

      // Overrun: second i_done_aes while serializing (FIFO full that cycle).
      step("o.cap",  0, 1, 0, 0, 34'h2_DDDDDDDD, 0, 0);
      step("o.hdr",  0, 0, 0, 1, 34'h1_00000004, 0, 0);
      step("o.w0",   0, 0, 0, 1, 34'h0_AAAAAAAA, 0, 0);
      step("o.ovr",  0, 1, 1, 0, 34'h0_BBBBBBBB, 0, 0);
      step("o.err1", 0, 0, 0, 0, 34'h0_BBBBBBBB, 0, 1);
      step("o.err2", 0, 1, 0, 0, 34'h0_BBBBBBBB, 0, 1);
      step("o.err3", 0, 0, 0, 0, 34'h0_BBBBBBBB, 0, 1);

      // Illegal length 6 on the first block.
      step("l6.rst", 1, 0, 0, 0, 34'h0_BBBBBBBB, 0, 1);
      bus.data_len = 8'd6;
      step("l6.cap", 0, 1, 0, 0, 34'h0_00000000, 0, 0);
      step("l6.e1",  0, 0, 0, 0, 34'h0_00000000, 0, 1);
      step("l6.e2",  0, 0, 0, 0, 34'h0_00000000, 0, 1);

      // Illegal length 0.
      step("l0.rst", 1, 0, 0, 0, 34'h0_00000000, 0, 1);
      bus.data_len = 8'd0;
      step("l0.cap", 0, 1, 0, 0, 34'h0_00000000, 0, 0);
      step("l0.e1",  0, 0, 0, 0, 34'h0_00000000, 0, 1);

      // Reset after the header of a two-block packet, then a fresh packet.
      step("r.rst0", 1, 0, 0, 0, 34'h0_00000000, 0, 1);
      cfg(1'b0, 8'd8, '0, BLK_X, '0);
      step("r.cap",  0, 1, 0, 0, 34'h0_00000000, 0, 0);
      step("r.hdr",  0, 0, 0, 1, 34'h1_00000008, 0, 0);
      step("r.rst1", 1, 0, 1, 0, 34'h0_FFEEDDCC, 0, 0);
      step("r.q1",   0, 0, 0, 0, 34'h0_00000000, 0, 0);
      bus.data_len = 8'd4;
      step("r.cap2", 0, 1, 0, 0, 34'h0_00000000, 0, 0);
      step("r.hdr2", 0, 0, 0, 1, 34'h1_00000004, 0, 0);
      step("r.w0",   0, 0, 0, 1, 34'h0_FFEEDDCC, 0, 0);
      step("r.w1",   0, 0, 0, 1, 34'h0_BBAA9988, 0, 0);
      step("r.w2",   0, 0, 0, 1, 34'h0_77665544, 0, 0);
      step("r.w3",   0, 0, 0, 1, 34'h2_33221100, 0, 0);
      step("r.dn",   0, 0, 0, 0, 34'h2_33221100, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
